// File: rtl/stream_frame_pkg.sv
// ---------------------------------------------------------------------------
// stream_frame_pkg
// Shared definitions for the framed 128-bit host stream: default header
// magic, header field offsets, deframer state encoding and a clog2 helper.
// Imported by both the receive-side deframer and the transmit-side writer.
// ---------------------------------------------------------------------------
package stream_frame_pkg;

   localparam logic [31:0] MAGIC_DEFAULT = 32'h5046524D;

   // Header field positions inside the 128-bit header beat
   localparam int unsigned LEN_LSB   = 0;
   localparam int unsigned LEN_MSB   = 31;
   localparam int unsigned MAGIC_LSB = 32;
   localparam int unsigned MAGIC_MSB = 63;

   typedef enum logic [0:0] {
      HDR = 1'b0,
      PAY = 1'b1
   } state_t;

   // Ceiling log2, usable in constant expressions
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/in_stream_deframer_if.sv
// ---------------------------------------------------------------------------
// in_stream_deframer_if
// Bundles both handshakes around the deframer:
//   128-bit input side : s128_valid, s128_data, s128_rdy
//   W-bit output side  : s_valid, s_data, s_last, s_rdy
// Modports:
//   slave  - the deframer (consumes 128-bit beats, produces W-bit words)
//   master - the surrounding environment (produces beats, consumes words)
// ---------------------------------------------------------------------------
interface in_stream_deframer_if #(
   parameter int W = 32
);
   logic           s128_valid;
   logic [127:0]   s128_data;
   logic           s128_rdy;
   logic           s_valid;
   logic           s_rdy;
   logic [W-1:0]   s_data;
   logic           s_last;

   modport slave (
      input  s128_valid, s128_data, s_rdy,
      output s128_rdy, s_valid, s_data, s_last
   );

   modport master (
      output s128_valid, s128_data, s_rdy,
      input  s128_rdy, s_valid, s_data, s_last
   );
endinterface

// File: rtl/stream_lane_mux.sv
// ---------------------------------------------------------------------------
// stream_lane_mux
// Selects one W-bit lane out of the 128-bit hold register. Lane 0 is bits
// [W-1:0]. An out-of-range lane index yields zero.
// Ports:
//   hold  in  128  held payload beat
//   lane  in  LW   lane index
//   word  out W    selected lane
// ---------------------------------------------------------------------------
module stream_lane_mux #(
   parameter int W     = 32,
   parameter int LANES = 128 / W,
   parameter int LW    = 3
) (
   input  logic [127:0]  hold,
   input  logic [LW-1:0] lane,
   output logic [W-1:0]  word
);

   // Lane select; zero when the index matches no lane
   always_comb begin
      word = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lane == LW'(i)) begin
            word = hold[i*W +: W];
         end else begin
            word = word;
         end
      end
   end

endmodule

// File: rtl/in_stream_deframer.sv
// ---------------------------------------------------------------------------
// in_stream_deframer
// Strips the header beat from a framed 128-bit stream and unpacks the payload
// into W-bit words, emitting exactly N words (N taken from the header) with
// s_last on the final one. Padding lanes of the final beat are dropped.
// Ports:
//   clk      in   core clock
//   rst      in   asynchronous active-high reset
//   bus      if   slave modport: 128-bit beat input, W-bit word output
//   hdr_err  out  one-cycle pulse when a bad-magic header is dropped
//   busy     out  high while a frame is in progress
// ---------------------------------------------------------------------------
module in_stream_deframer
   import stream_frame_pkg::*;
#(
   parameter int          W     = 32,
   parameter logic [31:0] MAGIC = MAGIC_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   in_stream_deframer_if.slave  bus,
   output logic                 hdr_err,
   output logic                 busy
);

   localparam int LANES = 128 / W;
   localparam int LW    = clog2(LANES) + 1;

   state_t         state_r,    state_n_s;
   logic [127:0]   hold_r,     hold_n_s;
   logic           hold_vld_r, hold_vld_n_s;
   logic [LW-1:0]  lane_r,     lane_n_s;
   logic [31:0]    remain_r,   remain_n_s;
   logic           hdr_err_r,  hdr_err_n_s;

   logic           s128_rdy_s;
   logic           beat_acc_s;
   logic           xfer_s;
   logic           last_lane_s;
   logic           last_word_s;
   logic [W-1:0]   word_s;

   assign xfer_s      = hold_vld_r & bus.s_rdy;
   assign last_lane_s = (lane_r == LW'(LANES - 1));
   assign last_word_s = (remain_r == 32'd1);
   assign beat_acc_s  = bus.s128_valid & s128_rdy_s;

   // Input ready: a new beat may refill the hold register in the same cycle as
   // its last lane leaves, but never on the final word of a frame, so the next
   // header is left for the HDR state.
   always_comb begin
      s128_rdy_s = 1'b1;
      case (state_r)
         HDR:     s128_rdy_s = 1'b1;
         PAY:     s128_rdy_s = !hold_vld_r || (xfer_s && last_lane_s && !last_word_s);
         default: s128_rdy_s = 1'b1;
      endcase
   end

   // Next-state and register update logic
   always_comb begin
      state_n_s    = state_r;
      hold_n_s     = hold_r;
      hold_vld_n_s = hold_vld_r;
      lane_n_s     = lane_r;
      remain_n_s   = remain_r;
      hdr_err_n_s  = 1'b0;
      case (state_r)
         HDR: begin
            if (beat_acc_s) begin
               if (bus.s128_data[MAGIC_MSB:MAGIC_LSB] != MAGIC) begin
                  hdr_err_n_s = 1'b1;
               end else if (bus.s128_data[LEN_MSB:LEN_LSB] == 32'd0) begin
                  state_n_s = HDR;
               end else begin
                  remain_n_s = bus.s128_data[LEN_MSB:LEN_LSB];
                  lane_n_s   = '0;
                  state_n_s  = PAY;
               end
            end else begin
               state_n_s = HDR;
            end
         end
         PAY: begin
            if (xfer_s) begin
               remain_n_s = remain_r - 32'd1;
               lane_n_s   = lane_r + LW'(1);
               if (last_lane_s) begin
                  hold_vld_n_s = 1'b0;
               end else begin
                  hold_vld_n_s = hold_vld_r;
               end
               if (last_word_s) begin
                  hold_vld_n_s = 1'b0;
                  state_n_s    = HDR;
               end else begin
                  state_n_s = PAY;
               end
            end else begin
               state_n_s = PAY;
            end
            // A beat load overrides the lane advance and the hold clear
            if (beat_acc_s) begin
               hold_n_s     = bus.s128_data;
               hold_vld_n_s = 1'b1;
               lane_n_s     = '0;
            end else begin
               hold_n_s = hold_r;
            end
         end
         default: begin
            state_n_s    = HDR;
            hold_vld_n_s = 1'b0;
            lane_n_s     = '0;
            remain_n_s   = 32'd0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= HDR;
         hold_r     <= '0;
         hold_vld_r <= 1'b0;
         lane_r     <= '0;
         remain_r   <= 32'd0;
         hdr_err_r  <= 1'b0;
      end else begin
         state_r    <= state_n_s;
         hold_r     <= hold_n_s;
         hold_vld_r <= hold_vld_n_s;
         lane_r     <= lane_n_s;
         remain_r   <= remain_n_s;
         hdr_err_r  <= hdr_err_n_s;
      end
   end

   stream_lane_mux #(
      .W     (W),
      .LANES (LANES),
      .LW    (LW)
   ) u_lane_mux (
      .hold (hold_r),
      .lane (lane_r),
      .word (word_s)
   );

   assign bus.s128_rdy = s128_rdy_s;
   assign bus.s_valid  = hold_vld_r;
   assign bus.s_data   = word_s;
   assign bus.s_last   = hold_vld_r & last_word_s;
   assign hdr_err      = hdr_err_r;
   assign busy         = (state_r != HDR);

endmodule

// File: tb/tb_in_stream_deframer.sv
// ---------------------------------------------------------------------------
// tb_in_stream_deframer
// Directed self-checking bench for in_stream_deframer with W=32.
// ---------------------------------------------------------------------------
module tb_in_stream_deframer;

   logic clk;
   logic rst;
   logic hdr_err;
   logic busy;
   int   checks;
   int   errors;

   in_stream_deframer_if #(.W(32)) bus ();

   in_stream_deframer #(.W(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .hdr_err (hdr_err),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] hdr(input logic [31:0] n);
      return {64'hFEDC_BA98_7654_3210, 32'h5046524D, n};
   endfunction

   // Check the presented word and its last flag
   task automatic check_word(input string tag, input logic [31:0] exp, input logic last);
      check_val({tag, "_valid"}, {127'd0, bus.s_valid}, 128'd1);
      check_val({tag, "_data"},  {96'd0, bus.s_data},   {96'd0, exp});
      check_val({tag, "_last"},  {127'd0, bus.s_last},  {127'd0, last});
   endtask

   logic [127:0] beat_a;
   logic [127:0] beat_b;
   logic [127:0] beat_p;
   logic [31:0]  exp_words[8];
   logic [3:0]   rdy_pat;
   int           idx;
   int           cyc;

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      bus.s128_valid = 1'b0;
      bus.s128_data  = 128'd0;
      bus.s_rdy      = 1'b0;
      beat_a = 128'h44444444_33333333_22222222_11111111;
      beat_b = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
      beat_p = 128'hCAFE0003_CAFE0002_CAFE0001_0000ABCD;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check_val("rst_s_valid",  {127'd0, bus.s_valid},  128'd0);
      check_val("rst_s_last",   {127'd0, bus.s_last},   128'd0);
      check_val("rst_s128_rdy", {127'd0, bus.s128_rdy}, 128'd1);
      check_val("rst_hdr_err",  {127'd0, hdr_err},      128'd0);
      check_val("rst_busy",     {127'd0, busy},         128'd0);
      check_val("rst_s_data",   {96'd0, bus.s_data},    128'd0);

      // Test 1: N=4, one beat, s_rdy=1
      bus.s_rdy      = 1'b1;
      bus.s128_valid = 1'b1;
      bus.s128_data  = hdr(32'd4);
      tick();
      check_val("t1_busy_hdr", {127'd0, busy},        128'd1);
      check_val("t1_noval",    {127'd0, bus.s_valid}, 128'd0);
      bus.s128_data = beat_a;
      tick();
      bus.s128_valid = 1'b0;
      check_word("t1_w0", 32'h11111111, 1'b0); tick();
      check_word("t1_w1", 32'h22222222, 1'b0); tick();
      check_word("t1_w2", 32'h33333333, 1'b0); tick();
      check_word("t1_w3", 32'h44444444, 1'b1); tick();
      check_val("t1_busy_end",  {127'd0, busy},        128'd0);
      check_val("t1_valid_end", {127'd0, bus.s_valid}, 128'd0);

      // Test 2: N=6 over two beats, valid held high, following header waits
      bus.s128_valid = 1'b1;
      bus.s128_data  = hdr(32'd6);
      tick();
      bus.s128_data = beat_a;
      tick();
      bus.s128_data = beat_b;
      check_val("t2_rdy_full", {127'd0, bus.s128_rdy}, 128'd0);
      check_word("t2_w0", 32'h11111111, 1'b0); tick();
      check_word("t2_w1", 32'h22222222, 1'b0); tick();
      check_word("t2_w2", 32'h33333333, 1'b0); tick();
      check_word("t2_w3", 32'h44444444, 1'b0);
      check_val("t2_rdy_refill", {127'd0, bus.s128_rdy}, 128'd1);
      tick();
      bus.s128_data = hdr(32'd1);
      check_word("t2_w4", 32'hBBBB0000, 1'b0);
      check_val("t2_rdy_w4", {127'd0, bus.s128_rdy}, 128'd0);
      tick();
      check_word("t2_w5", 32'hBBBB0001, 1'b1);
      check_val("t2_rdy_last", {127'd0, bus.s128_rdy}, 128'd0);
      tick();
      check_val("t2_busy_end",  {127'd0, busy},         128'd0);
      check_val("t2_valid_end", {127'd0, bus.s_valid},  128'd0);
      check_val("t2_hdr_wait",  {127'd0, bus.s128_rdy}, 128'd1);
      tick();
      check_val("t2_hdr_taken", {127'd0, busy}, 128'd1);
      bus.s128_data = beat_p;
      tick();
      bus.s128_valid = 1'b0;
      check_word("t2_n1", 32'h0000ABCD, 1'b1);
      tick();
      check_val("t2_n1_done", {127'd0, busy}, 128'd0);

      // Test 3: bad magic, then a good frame
      bus.s128_valid = 1'b1;
      bus.s128_data  = {64'd0, 32'hDEADBEEF, 32'd4};
      tick();
      bus.s128_valid = 1'b0;
      check_val("t3_err_hi",  {127'd0, hdr_err},     128'd1);
      check_val("t3_busy",    {127'd0, busy},        128'd0);
      check_val("t3_noval",   {127'd0, bus.s_valid}, 128'd0);
      tick();
      check_val("t3_err_lo",  {127'd0, hdr_err},     128'd0);

      // Test 4: empty frame, then N=1 frame (also the recovery after bad magic)
      bus.s128_valid = 1'b1;
      bus.s128_data  = hdr(32'd0);
      tick();
      check_val("t4_empty_busy",  {127'd0, busy},        128'd0);
      check_val("t4_empty_err",   {127'd0, hdr_err},     128'd0);
      check_val("t4_empty_noval", {127'd0, bus.s_valid}, 128'd0);
      bus.s128_data = hdr(32'd1);
      tick();
      check_val("t4_busy", {127'd0, busy}, 128'd1);
      bus.s128_data = beat_p;
      tick();
      bus.s128_valid = 1'b0;
      check_word("t4_w0", 32'h0000ABCD, 1'b1);
      tick();
      check_val("t4_busy_end",  {127'd0, busy},        128'd0);
      check_val("t4_valid_end", {127'd0, bus.s_valid}, 128'd0);

      // Test 5: N=8 with s_rdy pattern 1,0,0,1
      exp_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                    32'hBBBB0000, 32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003};
      rdy_pat = 4'b1001;
      bus.s128_valid = 1'b1;
      bus.s128_data  = hdr(32'd8);
      tick();
      bus.s128_data = beat_a;
      tick();
      bus.s128_data = beat_b;
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 40) begin
         bus.s_rdy = rdy_pat[cyc % 4];
         #1;
         check_word($sformatf("t5_w%0d_c%0d", idx, cyc), exp_words[idx], (idx == 7));
         if (!bus.s_rdy) begin
            check_val($sformatf("t5_rdy_stall_c%0d", cyc), {127'd0, bus.s128_rdy}, 128'd0);
         end
         if (bus.s_rdy) begin
            idx++;
         end
         tick();
         if (idx == 4) begin
            bus.s128_valid = 1'b0;
         end
         cyc++;
      end
      check_val("t5_count", idx, 128'd8);
      check_val("t5_busy_end",  {127'd0, busy},        128'd0);
      check_val("t5_valid_end", {127'd0, bus.s_valid}, 128'd0);

      // Test 6: async reset mid-frame after two words of N=8
      bus.s_rdy      = 1'b1;
      bus.s128_valid = 1'b1;
      bus.s128_data  = hdr(32'd8);
      tick();
      bus.s128_data = beat_a;
      tick();
      bus.s128_valid = 1'b0;
      check_word("t6_w0", 32'h11111111, 1'b0); tick();
      check_word("t6_w1", 32'h22222222, 1'b0); tick();
      #2;
      rst = 1'b1;
      #1;
      check_val("t6_rst_valid", {127'd0, bus.s_valid}, 128'd0);
      check_val("t6_rst_busy",  {127'd0, busy},        128'd0);
      check_val("t6_rst_data",  {96'd0, bus.s_data},   128'd0);
      check_val("t6_rst_last",  {127'd0, bus.s_last},  128'd0);
      tick();
      rst = 1'b0;
      check_val("t6_rdy_after", {127'd0, bus.s128_rdy}, 128'd1);
      bus.s128_valid = 1'b1;
      bus.s128_data  = hdr(32'd1);
      tick();
      check_val("t6_hdr_busy", {127'd0, busy},    128'd1);
      check_val("t6_hdr_err",  {127'd0, hdr_err}, 128'd0);
      bus.s128_data = beat_p;
      tick();
      bus.s128_valid = 1'b0;
      check_word("t6_w_after", 32'h0000ABCD, 1'b1);
      tick();
      check_val("t6_busy_end", {127'd0, busy}, 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
